// File: rtl/spm_boot_memory_if.sv
// Load port and CPU memory port of spm_boot_memory, bundled as one interface.
// master: the side that offers load words and issues CPU accesses (bench or core wrapper).
// slave : the memory itself.
interface spm_boot_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  // Image load handshake (word accepted when load_valid && load_ready)
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_last;

  // CPU access port (asynchronous read, synchronous write)
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output load_valid, load_addr, load_data, load_last,
    output mem_addr, mem_wdata, mem_we,
    input  load_ready, mem_rdata
  );

  modport slave (
    input  load_valid, load_addr, load_data, load_last,
    input  mem_addr, mem_wdata, mem_we,
    output load_ready, mem_rdata
  );
endinterface

// File: rtl/spm_boot_memory.sv
// Unified program/data RAM for the RISC_SPM core with a boot sequencer:
// CLEAR sweeps every word to zero, LOAD accepts a program image over the
// load handshake, RUN releases the core and serves its accesses.
// Optional feature: define BOOT_CHECKSUM_EN to add the load_sum output, the
// modulo-2**DATA_W sum of every accepted load word (including dropped ones).
module spm_boot_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256   // must be <= 2**ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  spm_boot_memory_if.slave   bus,
  input  logic               boot_req,
  output logic               cpu_rst,
  output logic               boot_done,
  output logic               addr_err
`ifdef BOOT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]  load_sum
`endif
);

  typedef enum logic [1:0] {ST_CLEAR, ST_LOAD, ST_RUN} state_e;

  // DEPTH compared one bit wider so DEPTH == 2**ADDR_W stays representable.
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              addr_err_q, addr_err_d;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic load_in_range;
  logic cpu_in_range;

  assign load_in_range = ({1'b0, bus.load_addr} < DEPTH_W);
  assign cpu_in_range  = ({1'b0, bus.mem_addr}  < DEPTH_W);

`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  // Next-state logic and the single RAM write port shared by sweep, load and CPU.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    addr_err_d = addr_err_q;
    wr_en      = 1'b0;
    wr_addr    = clr_cnt_q;
    wr_data    = '0;
`ifdef BOOT_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    unique case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_addr   = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          clr_cnt_d = '0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (bus.load_valid) begin
          if (load_in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.load_addr;
            wr_data = bus.load_data;
          end else begin
            addr_err_d = 1'b1;
          end
`ifdef BOOT_CHECKSUM_EN
          sum_d = sum_q + bus.load_data;
`endif
          if (bus.load_last) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // A CPU write is honoured even on the edge that takes a warm reboot.
        if (bus.mem_we) begin
          if (cpu_in_range) begin
            wr_en   = 1'b1;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (boot_req) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
`ifdef BOOT_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end

      default: state_d = ST_CLEAR;
    endcase
  end

  // Sequencer state, sweep counter and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together on the edge.
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      addr_err_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_err_q <= addr_err_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // RAM write port; contents are wiped by the CLEAR sweep instead of by reset.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset branch so it maps onto plain RAM; the sweep does the clearing.
    if (!rst && wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Asynchronous CPU read, visible only while the core is running.
  always_comb begin
    bus.mem_rdata = '0;
    if (state_q == ST_RUN && cpu_in_range) bus.mem_rdata = mem_q[bus.mem_addr];
  end

  assign bus.load_ready = (state_q == ST_LOAD);
  assign cpu_rst        = (state_q != ST_RUN);
  assign boot_done      = (state_q == ST_RUN);
  assign addr_err       = addr_err_q;
`ifdef BOOT_CHECKSUM_EN
  assign load_sum       = sum_q;
`endif

endmodule

// File: tb/tb_spm_boot_memory.sv
// Directed bench for spm_boot_memory (DEPTH=200 so the out-of-range paths are reachable).
module tb_spm_boot_memory;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic boot_req = 1'b0;
  logic cpu_rst, boot_done, addr_err;
`ifdef BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum;
`endif

  int errors = 0;
  int checks = 0;

  spm_boot_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  spm_boot_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .boot_req  (boot_req),
    .cpu_rst   (cpu_rst),
    .boot_done (boot_done),
    .addr_err  (addr_err)
`ifdef BOOT_CHECKSUM_EN
    ,
    .load_sum  (load_sum)
`endif
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic sweep();
    repeat (DEPTH) tick();
  endtask

  // Offer one load word for one edge; load_valid is left high for back-to-back use.
  task automatic send(input int a, input int d, input bit last);
    bus.load_valid = 1'b1;
    bus.load_addr  = ADDR_W'(a);
    bus.load_data  = DATA_W'(d);
    bus.load_last  = last;
    tick();
  endtask

  task automatic read_expect(input string name, input int a, input int exp);
    bus.mem_addr = ADDR_W'(a);
    #1;
    checks++;
    if (bus.mem_rdata !== DATA_W'(exp)) begin
      errors++;
      $display("FAIL %s: mem[%0d] got 0x%02h expected 0x%02h", name, a, bus.mem_rdata, DATA_W'(exp));
    end
  endtask

  task automatic test_reset();
    pulse_rst();
    checks += 4;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.load_ready); end
    if (cpu_rst !== 1'b1)        begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL reset_boot_done: got %b expected 0", boot_done); end
    if (addr_err !== 1'b0)       begin errors++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    repeat (DEPTH-1) tick();
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL sweep_early: ready got %b expected 0", bus.load_ready); end
    tick();
    checks += 3;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL sweep_end_ready: got %b expected 1", bus.load_ready); end
    if (cpu_rst !== 1'b1)        begin errors++; $display("FAIL sweep_end_cpu_rst: got %b expected 1", cpu_rst); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL sweep_end_boot_done: got %b expected 0", boot_done); end
    read_expect("load_rdata_zero", 1, 0);
  endtask

  task automatic test_image_load();
    int ra[5] = '{1, 2, 128, 139, 3};
    int rd[5] = '{8'h52, 8'h82, 8'h06, 8'hF0, 8'h00};
    send(1, 8'h52, 1'b0);
    send(2, 130, 1'b0);
    send(128, 6, 1'b0);
    checks += 2;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL mid_load_ready: got %b expected 1", bus.load_ready); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL mid_load_done: got %b expected 0", boot_done); end
    send(139, 8'hF0, 1'b1);
    bus.load_valid = 1'b0;
    checks += 3;
    if (boot_done !== 1'b1)      begin errors++; $display("FAIL run_boot_done: got %b expected 1", boot_done); end
    if (cpu_rst !== 1'b0)        begin errors++; $display("FAIL run_cpu_rst: got %b expected 0", cpu_rst); end
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL run_ready: got %b expected 0", bus.load_ready); end
    for (int i = 0; i < 5; i++) read_expect("image_word", ra[i], rd[i]);
  endtask

  task automatic test_run_access();
    read_expect("run_read_128", 128, 6);
    bus.mem_addr  = 8'd140;
    bus.mem_wdata = 8'd9;
    bus.mem_we    = 1'b1;
    tick();
    bus.mem_we = 1'b0;
    read_expect("run_write_140", 140, 9);
    // Load port must be ignored while running.
    send(141, 8'h5A, 1'b1);
    bus.load_valid = 1'b0;
    read_expect("run_load_ignored", 141, 0);
    checks++;
    if (boot_done !== 1'b1) begin errors++; $display("FAIL run_stays: boot_done got %b expected 1", boot_done); end
  endtask

  task automatic test_cpu_range();
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL cpu_range_pre: addr_err got %b expected 0", addr_err); end
    read_expect("cpu_read_oor", 250, 0);
    bus.mem_addr  = 8'd250;
    bus.mem_wdata = 8'h3C;
    bus.mem_we    = 1'b1;
    tick();
    bus.mem_we = 1'b0;
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL cpu_write_oor: addr_err got %b expected 1", addr_err); end
    read_expect("cpu_oor_no_alias", 50, 0);
  endtask

  task automatic test_reboot();
    boot_req      = 1'b1;
    bus.mem_addr  = 8'd5;
    bus.mem_wdata = 8'h77;
    bus.mem_we    = 1'b1;
    tick();
    boot_req   = 1'b0;
    bus.mem_we = 1'b0;
    checks += 4;
    if (cpu_rst !== 1'b1)        begin errors++; $display("FAIL reboot_cpu_rst: got %b expected 1", cpu_rst); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL reboot_done: got %b expected 0", boot_done); end
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reboot_ready: got %b expected 0", bus.load_ready); end
    if (addr_err !== 1'b1)       begin errors++; $display("FAIL reboot_addr_err_kept: got %b expected 1", addr_err); end
    repeat (DEPTH-1) tick();
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL reboot_sweep_early: ready got %b expected 0", bus.load_ready); end
    tick();
    checks++;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reboot_sweep_end: ready got %b expected 1", bus.load_ready); end
    send(0, 8'hAA, 1'b1);
    bus.load_valid = 1'b0;
    read_expect("reboot_new_word", 0, 8'hAA);
    read_expect("reboot_wiped_1", 1, 0);
    read_expect("reboot_wiped_128", 128, 0);
    read_expect("reboot_wiped_139", 139, 0);
    read_expect("reboot_wiped_140", 140, 0);
    read_expect("reboot_wiped_5", 5, 0);
  endtask

  task automatic test_range_load();
    pulse_rst();
    checks++;
    if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_clears_addr_err: got %b expected 0", addr_err); end
    sweep();
    send(220, 8'h77, 1'b0);
    checks++;
    if (addr_err !== 1'b1) begin errors++; $display("FAIL load_oor_err: got %b expected 1", addr_err); end
    send(5, 8'h11, 1'b1);
    bus.load_valid = 1'b0;
    read_expect("load_after_oor", 5, 8'h11);
    read_expect("load_oor_no_alias", 20, 0);
    read_expect("load_oor_read_220", 220, 0);
    read_expect("load_oor_read_250", 250, 0);
  endtask

  task automatic test_fill_clear();
    int nonzero = 0;
    bus.mem_we    = 1'b1;
    bus.mem_wdata = 8'hFF;
    for (int a = 0; a < DEPTH; a++) begin
      bus.mem_addr = ADDR_W'(a);
      tick();
    end
    bus.mem_we = 1'b0;
    read_expect("fill_first", 0, 8'hFF);
    read_expect("fill_last", DEPTH-1, 8'hFF);
    pulse_rst();
    sweep();
    send(DEPTH-1, 8'h01, 1'b1);
    bus.load_valid = 1'b0;
    for (int a = 0; a < DEPTH-1; a++) begin
      bus.mem_addr = ADDR_W'(a);
      #1;
      if (bus.mem_rdata !== 8'h00) nonzero++;
    end
    checks++;
    if (nonzero !== 0) begin errors++; $display("FAIL clear_all_words: nonzero words got %0d expected 0", nonzero); end
    read_expect("clear_then_load", DEPTH-1, 8'h01);
  endtask

  task automatic test_rst_mid_load();
    pulse_rst();
    sweep();
    send(10, 8'h44, 1'b0);
    bus.load_valid = 1'b0;
    tick();
    checks += 2;
    if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL gap_ready: got %b expected 1", bus.load_ready); end
    if (boot_done !== 1'b0)      begin errors++; $display("FAIL gap_done: got %b expected 0", boot_done); end
    send(11, 8'h55, 1'b0);
    bus.load_valid = 1'b0;
    pulse_rst();
    checks++;
    if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_load_ready: got %b expected 0", bus.load_ready); end
    sweep();
    send(12, 8'h66, 1'b1);
    bus.load_valid = 1'b0;
    read_expect("rst_mid_load_wiped_10", 10, 0);
    read_expect("rst_mid_load_wiped_11", 11, 0);
    read_expect("rst_mid_load_new_12", 12, 8'h66);
  endtask

`ifdef BOOT_CHECKSUM_EN
  task automatic test_checksum();
    pulse_rst();
    checks++;
    if (load_sum !== 8'h00) begin errors++; $display("FAIL sum_reset: got 0x%02h expected 0x00", load_sum); end
    sweep();
    send(30, 8'hF0, 1'b0);
    send(250, 8'h20, 1'b0);
    send(32, 8'h05, 1'b1);
    checks++;
    if (load_sum !== 8'h15) begin errors++; $display("FAIL sum_run: got 0x%02h expected 0x15", load_sum); end
    send(33, 8'h40, 1'b0);
    bus.load_valid = 1'b0;
    checks++;
    if (load_sum !== 8'h15) begin errors++; $display("FAIL sum_frozen: got 0x%02h expected 0x15", load_sum); end
  endtask
`endif

  initial begin
    bus.load_valid = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_we     = 1'b0;
    test_reset();
    test_image_load();
    test_run_access();
    test_cpu_range();
    test_reboot();
    test_range_load();
    test_fill_clear();
    test_rst_mid_load();
`ifdef BOOT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
